// File: rtl/axis2fifo_if.sv
// rtl/axis2fifo_if.sv - AXI-Stream style result channel between accelerator and axis2fifo
interface axis2fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis2fifo.sv
// rtl/axis2fifo.sv - stream slave buffering result frames into a circular FIFO with a registered read port
// Optional frame statistics (frame_count, last_frame_len) enabled by AXIS2FIFO_FRAME_CNT_EN.
module axis2fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int FRAME_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axis2fifo_if.slave                 s_axis,
  input  logic                       arm,
  input  logic                       read,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       frame_done,
  output logic                       err_short,
  output logic                       err_nolast,
  output logic                       err_underflow
`ifdef AXIS2FIFO_FRAME_CNT_EN
  ,
  output logic [7:0]                 frame_count,
  output logic [$clog2(DEPTH):0]     last_frame_len
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [PW-1:0] PTR_ONE     = PW'(1);

  typedef enum logic {
    IDLE,
    RECEIVE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         beat_cnt;
  logic [CW-1:0]         beat_next;
  logic                  push;
  logic                  pop;
  logic                  len_hit;
  logic                  frame_end;

  // Ready depends only on state and occupancy so the accelerator never sees a tvalid loop.
  assign full          = (level == DEPTH_C);
  assign empty         = (level == '0);
  assign s_axis.tready = (state == RECEIVE) && !full;

  assign push      = s_axis.tvalid && s_axis.tready;
  assign pop       = read && !empty;
  assign beat_next = beat_cnt + CNT_ONE;
  assign len_hit   = (beat_next == FRAME_LEN_C);
  assign frame_end = push && (s_axis.tlast || len_hit);

  // Storage is deliberately left out of reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis.tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      beat_cnt      <= '0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      frame_done    <= 1'b0;
      err_short     <= 1'b0;
      err_nolast    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      dout_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (arm) begin
            state         <= RECEIVE;
            beat_cnt      <= '0;
            err_short     <= 1'b0;
            err_nolast    <= 1'b0;
            err_underflow <= 1'b0;
          end
        end
        RECEIVE: begin
          if (push) begin
            beat_cnt <= beat_next;
            if (frame_end) begin
              frame_done <= 1'b1;
              state      <= IDLE;
              if (s_axis.tlast && !len_hit) begin
                err_short <= 1'b1;
              end
              if (len_hit && !s_axis.tlast) begin
                err_nolast <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      // Read side runs regardless of FSM state; an empty read only raises the sticky flag.
      if (read) begin
        if (!empty) begin
          dout       <= mem[rd_ptr];
          dout_valid <= 1'b1;
          rd_ptr     <= rd_ptr + PTR_ONE;
        end else begin
          err_underflow <= 1'b1;
        end
      end

      case ({push, pop})
        2'b10:   level <= level + CNT_ONE;
        2'b01:   level <= level - CNT_ONE;
        default: level <= level;
      endcase
    end
  end

`ifdef AXIS2FIFO_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count    <= '0;
      last_frame_len <= '0;
    end else if (state == RECEIVE && frame_end) begin
      frame_count    <= frame_count + 8'd1;
      last_frame_len <= beat_next;
    end
  end
`endif

endmodule

// File: tb/tb_axis2fifo.sv
// tb/tb_axis2fifo.sv - directed self-checking bench for axis2fifo (DEPTH=4, FRAME_LEN=4)
module tb_axis2fifo;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        read;
  logic [31:0] dout;
  logic        dout_valid;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic        frame_done;
  logic        err_short;
  logic        err_nolast;
  logic        err_underflow;
`ifdef AXIS2FIFO_FRAME_CNT_EN
  logic [7:0]  frame_count;
  logic [2:0]  last_frame_len;
`endif

  int total;
  int bad;

  axis2fifo_if #(.DATA_WIDTH(32)) s_axis ();

  axis2fifo #(
    .DATA_WIDTH(32),
    .DEPTH(4),
    .FRAME_LEN(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis        (s_axis),
    .arm           (arm),
    .read          (read),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .empty         (empty),
    .full          (full),
    .level         (level),
    .frame_done    (frame_done),
    .err_short     (err_short),
    .err_nolast    (err_nolast),
    .err_underflow (err_underflow)
`ifdef AXIS2FIFO_FRAME_CNT_EN
    ,
    .frame_count   (frame_count),
    .last_frame_len(last_frame_len)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    s_axis.tdata  = data;
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = last;
  endtask

  task automatic idle_bus();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tdata  = '0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  logic [31:0] nom [4];
  logic [31:0] fin [4];

  initial begin
    total = 0;
    bad   = 0;
    nom[0] = 32'h11; nom[1] = 32'h22; nom[2] = 32'h33; nom[3] = 32'h44;
    fin[0] = 32'h55; fin[1] = 32'h66; fin[2] = 32'h77; fin[3] = 32'h88;
    rst_n = 1'b0;
    arm   = 1'b0;
    read  = 1'b0;
    idle_bus();
    tick();
    tick();

    check("rst_tready", 32'(s_axis.tready), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_flags", {dout_valid, frame_done, err_short, err_nolast, err_underflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal frame
    do_arm();
    for (int i = 0; i < 4; i++) begin
      beat(nom[i], i == 3);
      check($sformatf("nom_tready%0d", i), 32'(s_axis.tready), 32'd1);
      tick();
      if (i < 3) check($sformatf("nom_fd_early%0d", i), 32'(frame_done), 32'd0);
    end
    idle_bus();
    check("nom_frame_done", 32'(frame_done), 32'd1);
    check("nom_level", 32'(level), 32'd4);
    check("nom_full", 32'(full), 32'd1);
    check("nom_err", {err_short, err_nolast}, 32'd0);
    tick();
    check("nom_fd_pulse", 32'(frame_done), 32'd0);
    read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("nom_dv%0d", i), 32'(dout_valid), 32'd1);
      check($sformatf("nom_dout%0d", i), dout, nom[i]);
    end
    read = 1'b0;
    check("nom_empty", 32'(empty), 32'd1);
    tick();
    check("nom_dv_off", 32'(dout_valid), 32'd0);

    // Short frame
    do_arm();
    beat(32'hA0, 1'b0);
    tick();
    beat(32'hA1, 1'b1);
    tick();
    check("short_frame_done", 32'(frame_done), 32'd1);
    check("short_err", 32'(err_short), 32'd1);
    check("short_level", 32'(level), 32'd2);
    beat(32'hA2, 1'b0);
    check("short_tready", 32'(s_axis.tready), 32'd0);
    tick();
    check("short_level_hold", 32'(level), 32'd2);
    idle_bus();

    // Missing tlast, each beat overlapped with a pop (level stays 2)
    do_arm();
    check("arm_clr_short", 32'(err_short), 32'd0);
    read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(32'hC0 + 32'(i), 1'b0);
      tick();
      check($sformatf("pp_level%0d", i), 32'(level), 32'd2);
      check($sformatf("pp_dout%0d", i), dout, (i == 0) ? 32'hA0 : (i == 1) ? 32'hA1 : 32'hC0 + 32'(i - 2));
    end
    read = 1'b0;
    check("nolast_err", 32'(err_nolast), 32'd1);
    check("nolast_frame_done", 32'(frame_done), 32'd1);
    check("nolast_short", 32'(err_short), 32'd0);
    beat(32'hC4, 1'b0);
    check("nolast_tready", 32'(s_axis.tready), 32'd0);
    tick();
    check("nolast_level", 32'(level), 32'd2);
    idle_bus();

    // Drain then underflow
    read = 1'b1;
    tick();
    check("drain_dout0", dout, 32'hC2);
    tick();
    check("drain_dout1", dout, 32'hC3);
    check("drain_empty", 32'(empty), 32'd1);
    tick();
    read = 1'b0;
    check("uf_err", 32'(err_underflow), 32'd1);
    check("uf_dout", dout, 32'hC3);
    check("uf_dv", 32'(dout_valid), 32'd0);
    check("uf_level", 32'(level), 32'd0);

    // Pre-fill 3 words with a short frame
    do_arm();
    check("arm_clr_uf", 32'(err_underflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      beat(32'hD0 + 32'(i), i == 2);
      tick();
    end
    idle_bus();
    check("pre_level", 32'(level), 32'd3);

    // Backpressure and wrap
    do_arm();
    beat(32'hE0, 1'b0);
    check("bp_tready0", 32'(s_axis.tready), 32'd1);
    tick();
    check("bp_full", 32'(full), 32'd1);
    beat(32'hE1, 1'b0);
    check("bp_tready_full", 32'(s_axis.tready), 32'd0);
    tick();
    check("bp_level_hold", 32'(level), 32'd4);
    read = 1'b1;
    tick();
    read = 1'b0;
    check("bp_pop_dout", dout, 32'hD0);
    check("bp_level3", 32'(level), 32'd3);
    check("bp_tready_back", 32'(s_axis.tready), 32'd1);
    tick();
    idle_bus();
    check("bp_level4", 32'(level), 32'd4);
    read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_dout%0d", i), dout, (i < 2) ? 32'hD1 + 32'(i) : 32'hE0 + 32'(i - 2));
    end
    tick();
    read = 1'b0;
    check("bp_uf", 32'(err_underflow), 32'd1);

    // Reset mid-frame (frame still open with 2 beats; push one more)
    beat(32'hF0, 1'b0);
    tick();
    idle_bus();
    check("mid_level", 32'(level), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_tready", 32'(s_axis.tready), 32'd0);
    check("mr_level", 32'(level), 32'd0);
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_err", {err_short, err_nolast, err_underflow}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_arm();
    for (int i = 0; i < 4; i++) begin
      beat(fin[i], i == 3);
      check($sformatf("fin_tready%0d", i), 32'(s_axis.tready), 32'd1);
      tick();
    end
    idle_bus();
    check("fin_frame_done", 32'(frame_done), 32'd1);
    check("fin_level", 32'(level), 32'd4);
    read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fin_dout%0d", i), dout, fin[i]);
    end
    read = 1'b0;
    check("fin_err", {err_short, err_nolast, err_underflow}, 32'd0);
    check("fin_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
